// File: rtl/wb_flash_reader_pkg.sv
// Shared constants and helpers for the Wishbone-to-NOR-flash read bridge.
package wb_flash_reader_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_READ = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;
   localparam logic [1:0] ST_ERR  = 2'd3;

   localparam int unsigned WB_DW  = 32;
   localparam int unsigned WAIT_W = 4;

   function automatic int unsigned beats_of(input int unsigned dw);
      return WB_DW / dw;
   endfunction

   // A single-beat bus still gets a 1-bit counter so ports keep a legal width.
   function automatic int unsigned beat_w_of(input int unsigned beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/wb_flash_reader_beat_seq.sv
// Wait-state and beat counters for one flash word; cleared whenever not running.
module wb_flash_reader_beat_seq
   import wb_flash_reader_pkg::*;
#(
   parameter int unsigned WAIT_CYC = 3,
   parameter int unsigned BEATS    = 4,
   parameter int unsigned BEAT_W   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run_i,
   output logic [BEAT_W-1:0] beat_q,
   output logic              sample_c,
   output logic              last_c
);

   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [BEAT_W-1:0] beat_d;

   assign sample_c = run_i && (wait_q == WAIT_W'(WAIT_CYC - 1));
   assign last_c   = sample_c && (beat_q == BEAT_W'(BEATS - 1));

   always_comb begin
      wait_d = '0;
      beat_d = '0;
      if (run_i) begin
         wait_d = sample_c ? '0 : wait_q + WAIT_W'(1);
         beat_d = beat_q;
         if (sample_c) begin
            beat_d = last_c ? '0 : beat_q + BEAT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_q <= '0;
         beat_q <= '0;
      end else begin
         wait_q <= wait_d;
         beat_q <= beat_d;
      end
   end

endmodule

// File: rtl/wb_flash_reader.sv
// Read-only Wishbone classic slave assembling 32-bit words from a parallel NOR flash.
module wb_flash_reader
   import wb_flash_reader_pkg::*;
#(
   parameter int unsigned FLASH_DW   = 8,
   parameter int unsigned FLASH_AW   = 22,
   parameter int unsigned WAIT_CYC   = 3,
   parameter bit          BIG_ENDIAN = 1'b1
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_ni,
   input  logic                wb_cyc_i,
   input  logic                wb_stb_i,
   input  logic                wb_we_i,
   input  logic [31:0]         wb_adr_i,
   input  logic [31:0]         wb_dat_i,
   input  logic [3:0]          wb_sel_i,
   output logic [31:0]         wb_dat_o,
   output logic                wb_ack_o,
   output logic                wb_err_o,
   output logic [FLASH_AW-1:0] flash_adr_o,
   input  logic [FLASH_DW-1:0] flash_dat_i,
   output logic                flash_ce_n,
   output logic                flash_oe_n,
   output logic                flash_we_n,
   output logic                flash_rst_n
);

   localparam int unsigned BEATS  = beats_of(FLASH_DW);
   localparam int unsigned BEAT_W = beat_w_of(BEATS);
   localparam int unsigned BYTES  = FLASH_DW / 8;
   localparam int unsigned WA_W   = FLASH_AW - 2;

   if (!(FLASH_DW == 8 || FLASH_DW == 16 || FLASH_DW == 32)) begin : g_bad_dw
      $error("wb_flash_reader: FLASH_DW must be 8, 16 or 32");
   end
   if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait
      $error("wb_flash_reader: WAIT_CYC must be in 1..15");
   end
   if (FLASH_AW < 3 || FLASH_AW > 31) begin : g_bad_aw
      $error("wb_flash_reader: FLASH_AW must be in 3..31");
   end

   logic [1:0]          state_q, state_d;
   logic                ack_q, ack_d, err_q, err_d;
   logic                ce_n_q, ce_n_d, oe_n_q, oe_n_d;
   logic [WA_W-1:0]     word_adr_q, word_adr_d;
   logic [FLASH_AW-1:0] fadr_q, fadr_d;
   logic [WB_DW-1:0]    shift_q, shift_d, dat_q, dat_d;
   logic [WB_DW-1:0]    word_c;
   logic [BEAT_W-1:0]   beat_q;
   logic                acc_c, run_c, sample_c, last_c;
   logic [1:0]          nx_off_c;
   int unsigned         beat_nx_c;
   logic                unused_c;

   assign acc_c    = wb_cyc_i & wb_stb_i;
   assign run_c    = (state_q == ST_READ) && acc_c;
   assign unused_c = ^{wb_dat_i, wb_sel_i, wb_adr_i[WB_DW-1:FLASH_AW], wb_adr_i[1:0]};

   wb_flash_reader_beat_seq #(
      .WAIT_CYC (WAIT_CYC),
      .BEATS    (BEATS),
      .BEAT_W   (BEAT_W)
   ) u_seq (
      .clk      (wb_clk_i),
      .rst_n    (wb_rst_ni),
      .run_i    (run_c),
      .beat_q   (beat_q),
      .sample_c (sample_c),
      .last_c   (last_c)
   );

   // Beat offset lives in the low two bits only, so it never carries into the word address.
   always_comb begin
      beat_nx_c = last_c ? 0 : 32'(beat_q) + 1;
      nx_off_c  = 2'(beat_nx_c * BYTES);
   end

   // Merge the sampled beat into its byte lane of the partial word.
   if (BEATS == 1) begin : g_single
      assign word_c = WB_DW'(flash_dat_i);
   end else begin : g_lanes
      for (genvar g = 0; g < BEATS; g++) begin : g_lane
         localparam int unsigned LANE = BIG_ENDIAN ? (BEATS - 1 - g) : g;
         assign word_c[LANE*FLASH_DW +: FLASH_DW] = (beat_q == BEAT_W'(g)) ?
            flash_dat_i : shift_q[LANE*FLASH_DW +: FLASH_DW];
      end
   end

   always_comb begin
      state_d    = state_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      ce_n_d     = ce_n_q;
      oe_n_d     = oe_n_q;
      word_adr_d = word_adr_q;
      fadr_d     = fadr_q;
      shift_d    = shift_q;
      dat_d      = dat_q;
      case (state_q)
         ST_IDLE: begin
            if (acc_c) begin
               if (wb_we_i) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end else begin
                  state_d    = ST_READ;
                  word_adr_d = wb_adr_i[FLASH_AW-1:2];
                  fadr_d     = {wb_adr_i[FLASH_AW-1:2], 2'b00};
                  ce_n_d     = 1'b0;
                  oe_n_d     = 1'b0;
               end
            end
         end
         ST_READ: begin
            if (!acc_c) begin
               state_d = ST_IDLE;
               ce_n_d  = 1'b1;
               oe_n_d  = 1'b1;
            end else if (sample_c) begin
               shift_d = word_c;
               fadr_d  = {word_adr_q, nx_off_c};
               if (last_c) begin
                  state_d = ST_ACK;
                  ack_d   = 1'b1;
                  ce_n_d  = 1'b1;
                  oe_n_d  = 1'b1;
                  dat_d   = word_c;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q    <= ST_IDLE;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         ce_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         word_adr_q <= '0;
         fadr_q     <= '0;
         shift_q    <= '0;
         dat_q      <= '0;
      end else begin
         state_q    <= state_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         ce_n_q     <= ce_n_d;
         oe_n_q     <= oe_n_d;
         word_adr_q <= word_adr_d;
         fadr_q     <= fadr_d;
         shift_q    <= shift_d;
         dat_q      <= dat_d;
      end
   end

   assign wb_dat_o    = dat_q;
   assign wb_ack_o    = ack_q;
   assign wb_err_o    = err_q;
   assign flash_adr_o = fadr_q;
   assign flash_ce_n  = ce_n_q;
   assign flash_oe_n  = oe_n_q;
   assign flash_we_n  = 1'b1;
   assign flash_rst_n = wb_rst_ni;

endmodule

// File: tb/tb_wb_flash_reader.sv
// Scoreboard bench: three reader configurations (8-bit BE, 8-bit LE, 16-bit BE) on modelled flashes.
module tb_wb_flash_reader;

   typedef struct {
      bit          is_err;
      logic [31:0] dat;
      int          edge_n;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   int          cyc_cnt = 0;
   int          n_cmp = 0;
   int          n_fail = 0;

   logic        cyc [3];
   logic        stb [3];
   logic        we  [3];
   logic [31:0] adr [3];
   logic        ack [3];
   logic        err [3];
   logic [31:0] dat [3];
   logic [21:0] fadr [3];
   logic        ce_n [3];
   logic        oe_n [3];
   logic        we_n [3];
   logic        frst_n [3];
   logic [7:0]  fd8 [2];
   logic [15:0] fd16;

   exp_t        sbq [3][$];
   bit          chk_adr = 1'b0;
   int          cur_t0 = 0;
   logic [19:0] cur_word = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   wb_flash_reader #(.FLASH_DW(8), .FLASH_AW(22), .WAIT_CYC(3), .BIG_ENDIAN(1'b1)) u_be8 (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
      .wb_adr_i(adr[0]), .wb_dat_i(32'h0), .wb_sel_i(4'hF), .wb_dat_o(dat[0]), .wb_ack_o(ack[0]),
      .wb_err_o(err[0]), .flash_adr_o(fadr[0]), .flash_dat_i(fd8[0]), .flash_ce_n(ce_n[0]),
      .flash_oe_n(oe_n[0]), .flash_we_n(we_n[0]), .flash_rst_n(frst_n[0]));

   wb_flash_reader #(.FLASH_DW(8), .FLASH_AW(22), .WAIT_CYC(3), .BIG_ENDIAN(1'b0)) u_le8 (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
      .wb_adr_i(adr[1]), .wb_dat_i(32'h0), .wb_sel_i(4'hF), .wb_dat_o(dat[1]), .wb_ack_o(ack[1]),
      .wb_err_o(err[1]), .flash_adr_o(fadr[1]), .flash_dat_i(fd8[1]), .flash_ce_n(ce_n[1]),
      .flash_oe_n(oe_n[1]), .flash_we_n(we_n[1]), .flash_rst_n(frst_n[1]));

   wb_flash_reader #(.FLASH_DW(16), .FLASH_AW(22), .WAIT_CYC(3), .BIG_ENDIAN(1'b1)) u_be16 (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]), .wb_we_i(we[2]),
      .wb_adr_i(adr[2]), .wb_dat_i(32'h0), .wb_sel_i(4'hF), .wb_dat_o(dat[2]), .wb_ack_o(ack[2]),
      .wb_err_o(err[2]), .flash_adr_o(fadr[2]), .flash_dat_i(fd16), .flash_ce_n(ce_n[2]),
      .flash_oe_n(oe_n[2]), .flash_we_n(we_n[2]), .flash_rst_n(frst_n[2]));

   // Flash contents: 0x100..0x103 hold 11,22,33,44; every other byte equals its low address byte.
   function automatic logic [7:0] fbyte(input logic [21:0] a);
      case (a)
         22'h100: return 8'h11;
         22'h101: return 8'h22;
         22'h102: return 8'h33;
         22'h103: return 8'h44;
         default: return a[7:0];
      endcase
   endfunction

   always_comb begin
      for (int d = 0; d < 2; d++) begin
         fd8[d] = (!ce_n[d] && !oe_n[d]) ? fbyte(fadr[d]) : 8'hEE;
      end
      fd16 = (!ce_n[2] && !oe_n[2]) ? {fbyte(fadr[2]), fbyte(22'(fadr[2] + 22'd1))} : 16'hEEEE;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", nm, cyc_cnt, act, expv);
      end
   endtask

   // Response monitor: every ack/err must match the oldest expectation for that instance.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (rst_n && (ack[d] || err[d])) begin
            exp_t e;
            if (ack[d] && err[d]) chk("ack_err_both", 32'd1, 32'd0);
            if (sbq[d].size() == 0) begin
               chk($sformatf("unexpected_resp_dut%0d", d), 32'(ack[d]), 32'(0));
            end else begin
               e = sbq[d].pop_front();
               chk($sformatf("resp_is_err_dut%0d", d), 32'(err[d]), 32'(e.is_err));
               chk($sformatf("resp_edge_dut%0d", d), 32'(cyc_cnt), 32'(e.edge_n));
               if (!e.is_err) chk($sformatf("rd_data_dut%0d", d), dat[d], e.dat);
            end
         end
      end
      if (rst_n && chk_adr) begin
         int k;
         k = cyc_cnt - cur_t0;
         if (k >= 0 && k < 12) begin
            chk("beat_ce_oe_n", {30'b0, ce_n[0], oe_n[0]}, 32'd0);
            chk("beat_flash_adr", 32'(fadr[0]), 32'({cur_word, 2'(k / 3)}));
         end else if (k == 12) begin
            chk("ce_n_after_ack", 32'(ce_n[0]), 32'd1);
         end
      end
   end

   task automatic rd_start(input int d, input logic [31:0] a, input logic [31:0] expv);
      exp_t e;
      e.is_err = 1'b0;
      e.dat    = expv;
      e.edge_n = cyc_cnt + 1 + ((d == 2) ? 6 : 12);
      sbq[d].push_back(e);
      if (d == 0) begin
         cur_t0   = cyc_cnt + 1;
         cur_word = a[21:2];
      end
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b0; adr[d] = a;
   endtask

   task automatic wr_start(input int d, input logic [31:0] a);
      exp_t e;
      e.is_err = 1'b1;
      e.dat    = 32'h0;
      e.edge_n = cyc_cnt + 1;
      sbq[d].push_back(e);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b1; adr[d] = a;
   endtask

   task automatic wait_resp(input int d);
      bit got = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (ack[d] || err[d]) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk($sformatf("resp_timeout_dut%0d", d), 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int d);
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
   endtask

   task automatic chk_reset(input int d);
      chk($sformatf("rst_ack_dut%0d", d), 32'(ack[d]), 32'd0);
      chk($sformatf("rst_err_dut%0d", d), 32'(err[d]), 32'd0);
      chk($sformatf("rst_dat_dut%0d", d), dat[d], 32'd0);
      chk($sformatf("rst_fadr_dut%0d", d), 32'(fadr[d]), 32'd0);
      chk($sformatf("rst_ce_oe_dut%0d", d), {30'b0, ce_n[d], oe_n[d]}, 32'd3);
      chk($sformatf("rst_we_frst_dut%0d", d), {30'b0, we_n[d], frst_n[d]}, 32'd2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      for (int d = 0; d < 3; d++) begin
         cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; adr[d] = 32'h0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) chk_reset(d);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Big-endian byte read, then the same word through an address with junk above FLASH_AW.
      rd_start(0, 32'h0000_0100, 32'h1122_3344); wait_resp(0); idle(0);
      rd_start(0, 32'hFFC0_0100, 32'h1122_3344); wait_resp(0); idle(0);

      // Write is rejected with a one-cycle error and never touches the flash.
      wr_start(0, 32'h0000_0104); wait_resp(0);
      chk("wr_ce_n", 32'(ce_n[0]), 32'd1);
      idle(0);
      repeat (2) @(posedge clk);
      #1;

      // Abort mid-read: strobe dropped after edge 5.
      t0 = cyc_cnt + 1;
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h0000_0300;
      repeat (6) @(posedge clk);
      #1;
      idle(0);
      @(negedge clk);
      chk("abort_ce_n_before", 32'(ce_n[0]), 32'd0);
      @(negedge clk);
      chk("abort_cycle", 32'(cyc_cnt - t0), 32'd6);
      chk("abort_ce_oe_n", {30'b0, ce_n[0], oe_n[0]}, 32'd3);
      chk("abort_dat_kept", dat[0], 32'h1122_3344);
      repeat (20) @(posedge clk);
      #1;
      rd_start(0, 32'h0000_0200, 32'h0001_0203); wait_resp(0); idle(0);

      // Back-to-back with strobe held; per-beat flash address tracked by the monitor.
      chk_adr = 1'b1;
      rd_start(0, 32'h0000_00FC, 32'hFCFD_FEFF); wait_resp(0);
      rd_start(0, 32'h0000_0100, 32'h1122_3344); wait_resp(0); idle(0);
      chk_adr = 1'b0;
      @(posedge clk); #1;

      // Little-endian byte lanes and 16-bit flash.
      rd_start(1, 32'h0000_0100, 32'h4433_2211); wait_resp(1); idle(1);
      rd_start(1, 32'h0000_0200, 32'h0302_0100); wait_resp(1); idle(1);
      rd_start(2, 32'h0000_0100, 32'h1122_3344); wait_resp(2); idle(2);
      rd_start(2, 32'h0000_00FC, 32'hFCFD_FEFF); wait_resp(2); idle(2);
      @(posedge clk); #1;

      // Asynchronous reset after edge 7 of a read.
      rd_start(0, 32'h0000_0100, 32'h1122_3344);
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      sbq[0].delete();
      idle(0);
      #1;
      chk_reset(0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      rd_start(0, 32'h0000_0100, 32'h1122_3344); wait_resp(0); idle(0);
      repeat (4) @(posedge clk);
      #1;

      for (int d = 0; d < 3; d++) chk($sformatf("sb_empty_dut%0d", d), 32'(sbq[d].size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
